// File: rtl/ioctl_upload_reader_if.sv
// HPS ioctl upload-side signal bundle.
// master = hps_io side, slave = reader side.
interface ioctl_upload_reader_if #(
  parameter int DW = 8
);
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [DW-1:0] ioctl_din;
  logic          ioctl_wait;

  modport master (
    output ioctl_upload,
    output ioctl_rd,
    output ioctl_addr,
    input  ioctl_din,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_upload,
    input  ioctl_rd,
    input  ioctl_addr,
    output ioctl_din,
    output ioctl_wait
  );
endinterface

// File: rtl/ioctl_upload_reader.sv
// Serves HPS upload read-back from a spare dpram read port.
// One ioctl_rd -> one timed mem read; past-image bytes read as FILL.
module ioctl_upload_reader #(
  parameter int          AW     = 15,
  parameter int          DW     = 8,
  parameter int          RD_LAT = 1,
  parameter logic [DW-1:0] FILL = 8'hFF
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  ioctl_upload_reader_if.slave io,
  input  logic [AW:0]   image_size,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_q,
  output logic          busy,
  output logic          overrun,
  output logic [AW:0]   rd_count,
  output logic          upload_done
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, LAT, DONE
  } state_t;

  localparam logic [1:0]  LAT_LD = 2'(RD_LAT - 1);
  localparam logic [AW:0] SAT    = {1'b1, {AW{1'b0}}};

  state_t        state, nxt;
  logic [1:0]    cnt;
  logic [24:0]   addr_q;
  logic [DW-1:0] cap_q;
  logic          up_q;
  logic          rise, fall, accept, in_range;

  assign rise     = io.ioctl_upload & ~up_q;
  assign fall     = ~io.ioctl_upload & up_q;
  assign accept   = (state == IDLE) & io.ioctl_rd
                  & io.ioctl_upload;
  assign in_range = (addr_q[24:AW] == '0)
                  & (25'(image_size) > addr_q);
  assign mem_addr = addr_q[AW-1:0];

  // state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // next state; session end aborts from anywhere
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = ISSUE;
      ISSUE:   nxt = LAT;
      LAT:     if (cnt == '0) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (fall) nxt = IDLE;
  end

  // Moore outputs decoded from the state register
  always_comb begin
    mem_rd        = (state == ISSUE);
    busy          = (state != IDLE);
    io.ioctl_wait = (state != IDLE);
  end

  // latency counter, address and data capture
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      addr_q <= '0;
      cap_q  <= '0;
    end else begin
      if (accept) addr_q <= io.ioctl_addr;
      if (state == ISSUE)
        cnt <= LAT_LD;
      else if (state == LAT && cnt != '0)
        cnt <= cnt - 2'd1;
      if (state == LAT && cnt == '0)
        cap_q <= mem_q;
    end
  end

  // returned data, session counters, edge pulse
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      io.ioctl_din <= '0;
      rd_count     <= '0;
      overrun      <= 1'b0;
      upload_done  <= 1'b0;
      up_q         <= 1'b0;
    end else begin
      up_q        <= io.ioctl_upload;
      upload_done <= fall;
      if (io.ioctl_rd && state != IDLE)
        overrun <= 1'b1;
      if (state == DONE && !fall) begin
        io.ioctl_din <= in_range ? cap_q : FILL;
        if (rd_count != SAT)
          rd_count <= rd_count + 1'b1;
      end
      if (rise) begin
        rd_count <= '0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule
